// File: rtl/img_sram_pkg.sv
// Shared types for the image stream I/O block: controller states and the
// image SRAM control bundle.
package img_sram_pkg;

  localparam int PIX_W = 8;
  localparam int IDX_W = 8;
  // Wide enough for a skid FIFO occupancy of up to 4 entries.
  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    UNLOAD,
    DRAIN,
    FIN
  } img_state_e;

  typedef struct packed {
    logic             write_en;
    logic             sense_en;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic [PIX_W-1:0] din;
  } img_sram_ctrl_t;

endpackage

// File: rtl/img_skid_fifo.sv
// Small circular FIFO that buffers SRAM read data toward the pixel output
// stream. Push and pop in one cycle both take effect, including when full.
module img_skid_fifo
  import img_sram_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int B     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [B-1:0]     din_i,
  input  logic             pop_i,
  output logic [B-1:0]     dout_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [B-1:0]     mem_q [DEPTH];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/img_stream_io.sv
// Streams a row-major image into the image SRAM (LOAD) or out of it (UNLOAD)
// through a skid FIFO that absorbs the one-cycle SRAM read latency.
module img_stream_io
  import img_sram_pkg::*;
#(
  parameter int SKID_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] nrows,
  input  logic [IDX_W-1:0] ncols,
  input  logic             load_start,
  input  logic             unload_start,
  output logic             busy,
  output logic             done,
  input  logic             s_valid,
  input  logic [PIX_W-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [PIX_W-1:0] m_data,
  input  logic             m_ready,
  input  logic [PIX_W-1:0] sram_dout_in,
  output img_sram_ctrl_t   sram_ctrl,
  output img_state_e       dbg_state
);

  // Both streams use valid/ready: a beat transfers on the rising edge where
  // valid && ready; the sender holds data stable while valid && !ready.

  img_state_e       state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
  logic [IDX_W-1:0] nrows_q, nrows_d, ncols_q, ncols_d;
  logic             inflight_q, inflight_d;
  logic             advance, last_pix, issue_ok, fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occ, credit;

  assign last_pix = (row_q == nrows_q - 8'd1) && (col_q == ncols_q - 8'd1);
  assign fifo_pop = m_valid && m_ready;

  // A pop this cycle frees a slot before the next read lands, so it is
  // credited; without it m_ready=1 could not sustain one pixel per cycle.
  assign occ      = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign credit   = (CNT_W + 1)'(SKID_DEPTH) + {{CNT_W{1'b0}}, fifo_pop};
  assign issue_ok = (occ < credit);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    nrows_d    = nrows_q;
    ncols_d    = ncols_q;
    inflight_d = 1'b0;
    advance    = 1'b0;
    s_ready    = 1'b0;
    sram_ctrl  = '{write_en: 1'b0, sense_en: 1'b0, row: row_q, col: col_q, din: s_data};
    case (state_q)
      IDLE: begin
        if (load_start || unload_start) begin
          nrows_d = nrows;
          ncols_d = ncols;
          row_d   = '0;
          col_d   = '0;
          if (nrows == '0 || ncols == '0) state_d = FIN;
          else if (load_start)            state_d = LOAD;
          else                            state_d = UNLOAD;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          sram_ctrl.write_en = 1'b1;
          advance            = 1'b1;
          if (last_pix) state_d = FIN;
        end
      end
      UNLOAD: begin
        if (issue_ok) begin
          sram_ctrl.sense_en = 1'b1;
          inflight_d         = 1'b1;
          advance            = 1'b1;
          if (last_pix) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !inflight_q) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (advance) begin
      if (col_q == ncols_q - 8'd1) begin
        col_d = '0;
        row_d = row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      nrows_q    <= '0;
      ncols_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      nrows_q    <= nrows_d;
      ncols_q    <= ncols_d;
      inflight_q <= inflight_d;
    end
  end

  img_skid_fifo #(
    .DEPTH(SKID_DEPTH),
    .B    (PIX_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (inflight_q),
    .din_i  (sram_dout_in),
    .pop_i  (fifo_pop),
    .dout_o (m_data),
    .count_o(fifo_count),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  assign m_valid   = !fifo_empty;
  assign busy      = (state_q == LOAD) || (state_q == UNLOAD) || (state_q == DRAIN);
  assign done      = (state_q == FIN);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_img_stream_io.sv
// Directed bench for img_stream_io with a behavioural one-cycle-latency SRAM
// and scoreboards for SRAM writes and output pixels.
module tb_img_stream_io;
  import img_sram_pkg::*;

  localparam int DEPTH = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     nrows = '0, ncols = '0;
  logic           load_start = 1'b0, unload_start = 1'b0;
  logic           busy, done;
  logic           s_valid = 1'b0;
  logic [7:0]     s_data = '0;
  logic           s_ready;
  logic           m_valid;
  logic [7:0]     m_data;
  logic           m_ready = 1'b0;
  logic [7:0]     sram_dout;
  img_sram_ctrl_t sram_ctrl;
  img_state_e     dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  img_stream_io #(.SKID_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .nrows(nrows), .ncols(ncols),
    .load_start(load_start), .unload_start(unload_start),
    .busy(busy), .done(done),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .sram_dout_in(sram_dout), .sram_ctrl(sram_ctrl), .dbg_state(dbg_state)
  );

  // One-cycle-latency image SRAM
  logic [7:0] sram_mem [256];
  always @(posedge clk) begin
    if (sram_ctrl.write_en) sram_mem[{sram_ctrl.row[3:0], sram_ctrl.col[3:0]}] <= sram_ctrl.din;
    if (sram_ctrl.sense_en) sram_dout <= sram_mem[{sram_ctrl.row[3:0], sram_ctrl.col[3:0]}];
  end

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [23:0] wexp_q[$];
  int n_checks = 0, n_fail = 0;
  int wr_cnt, rd_cnt, pop_cnt, done_cnt, extra_wr, extra_pix;
  int first_done, first_pop, last_pop, issued, popped, max_occ;
  int t0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold) begin
        check("m_hold_valid", m_valid, 1);
        check("m_hold_data", m_data, prev_data);
      end
      if (sram_ctrl.write_en) begin
        wr_cnt++;
        if (wexp_q.size() > 0)
          check("sram_write", {sram_ctrl.row, sram_ctrl.col, sram_ctrl.din}, 32'(wexp_q.pop_front()));
        else extra_wr++;
      end
      if (sram_ctrl.sense_en) begin
        rd_cnt++;
        issued++;
      end
      if (m_valid && m_ready) begin
        pop_cnt++;
        popped++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (exp_q.size() > 0) check("m_data", m_data, exp_q.pop_front());
        else extra_pix++;
      end
      if (issued - popped > max_occ) max_occ = issued - popped;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
      end
    end
    prev_hold = !rst && m_valid && !m_ready;
    prev_data = m_data;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    wr_cnt = 0; rd_cnt = 0; pop_cnt = 0; done_cnt = 0; extra_wr = 0; extra_pix = 0;
    first_done = -1; first_pop = -1; last_pop = -1;
    issued = 0; popped = 0; max_occ = 0;
  endtask

  function automatic logic [7:0] pix(input int r, input int c, input logic [7:0] x);
    return 8'(r * 16 + c) ^ x;
  endfunction

  task automatic start(input logic ld, input logic ul, input logic [7:0] nr, input logic [7:0] nc);
    nrows = nr; ncols = nc; load_start = ld; unload_start = ul;
    t0 = cyc;
    tick();
    load_start = 1'b0; unload_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == 0 && k < 100) begin
      tick();
      k++;
    end
    check(tag, (done_cnt != 0), 1);
  endtask

  task automatic load_image(input int nr, input int nc, input logic [7:0] xv,
                            input logic gaps, input logic inject);
    int idx = 0, k = 0;
    logic acc;
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++) wexp_q.push_back({8'(r), 8'(c), pix(r, c, xv)});
    start(1'b1, inject, 8'(nr), 8'(nc));
    while (idx < nr * nc && k < 200) begin
      unload_start = inject && (k == 4);
      s_valid = gaps ? (k % 3 != 2) : 1'b1;
      s_data  = pix(idx / nc, idx % nc, xv);
      acc = s_valid && s_ready;
      if (k == 2) check("load_busy", busy, 1);
      tick();
      if (acc) idx++;
      k++;
    end
    s_valid = 1'b0; unload_start = 1'b0;
    wait_done("load_done_seen");
  endtask

  task automatic unload_image(input int nr, input int nc, input logic [7:0] xv,
                              input logic toggle, input int abort_at);
    int k = 0;
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++) exp_q.push_back(pix(r, c, xv));
    m_ready = 1'b1;
    start(1'b0, 1'b1, 8'(nr), 8'(nc));
    while (done_cnt == 0 && k < 200) begin
      if (abort_at > 0 && pop_cnt == abort_at) break;
      m_ready = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      tick();
      k++;
    end
  endtask

  task automatic check_unload(input int n, input logic timed);
    check("unload_done_count", done_cnt, 1);
    check("unload_pixels", pop_cnt, n);
    check("unload_reads", rd_cnt, n);
    check("unload_left", exp_q.size(), 0);
    check("unload_extra", extra_pix, 0);
    check("max_outstanding", max_occ, DEPTH);
    if (timed) begin
      check("first_m_valid", first_pop - t0, 3);
      check("back_to_back", last_pop - first_pop, n - 1);
      check("done_after_last", first_done - last_pop, 2);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    clear_stats();
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_write_en", sram_ctrl.write_en, 0);
    check("rst_sense_en", sram_ctrl.sense_en, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    tick();

    // 3x4 load, both starts together, stray unload_start mid-load
    clear_stats();
    load_image(3, 4, 8'h00, 1'b0, 1'b1);
    check("load_writes", wr_cnt, 12);
    check("load_done_cycle", first_done - t0, 13);
    check("load_left", wexp_q.size(), 0);
    check("load_extra", extra_wr, 0);
    check("load_no_reads", rd_cnt, 0);
    tick();
    check("load_done_count", done_cnt, 1);
    check("load_idle", dbg_state, IDLE);
    check("load_busy_after", busy, 0);

    // 3x4 unload with m_ready held high
    clear_stats();
    unload_image(3, 4, 8'h00, 1'b0, 0);
    tick();
    check_unload(12, 1'b1);

    // 2x6 load with s_valid gaps, unload with m_ready 1,0,0,1
    clear_stats();
    load_image(2, 6, 8'h5A, 1'b1, 1'b0);
    check("load26_writes", wr_cnt, 12);
    check("load26_left", wexp_q.size(), 0);
    tick();
    clear_stats();
    unload_image(2, 6, 8'h5A, 1'b1, 0);
    tick();
    check_unload(12, 1'b0);

    // Zero-sized image
    clear_stats();
    start(1'b1, 1'b0, 8'd0, 8'd5);
    check("zero_done_next", done, 1);
    check("zero_busy", busy, 0);
    tick();
    check("zero_done_once", done, 0);
    repeat (2) tick();
    check("zero_writes", wr_cnt, 0);
    check("zero_done_count", done_cnt, 1);

    // 4x4: abort an unload after 5 pixels, then unload again
    clear_stats();
    load_image(4, 4, 8'hC3, 1'b0, 1'b0);
    check("load44_writes", wr_cnt, 16);
    tick();
    clear_stats();
    unload_image(4, 4, 8'hC3, 1'b0, 5);
    check("abort_pixels", pop_cnt, 5);
    rst = 1'b1; m_ready = 1'b0;
    tick();
    check("abort_m_valid", m_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sense_en", sram_ctrl.sense_en, 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (5) tick();
    check("abort_no_done", done_cnt, 0);
    clear_stats();
    unload_image(4, 4, 8'hC3, 1'b0, 0);
    tick();
    check_unload(16, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
